// File: rtl/lamp_state_decoder.sv
// Serial read-back decoder for the 16-lamp bar: counts lit lamps and
// checks that the pattern is a thermometer code, one lamp per clock.
module lamp_state_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] lights_state,
    output logic        busy,
    output logic        done,
    output logic [4:0]  active_lights,
    output logic        valid_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] snap;
    logic [4:0]  ones;
    logic [3:0]  index;
    logic        seen_zero;
    logic        gap_error;

    logic        lamp;
    logic [4:0]  ones_next;
    logic        gap_next;

    always_comb begin
        lamp      = snap[0];
        ones_next = ones + {4'd0, lamp};
        gap_next  = gap_error | (lamp & seen_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            snap          <= '0;
            ones          <= '0;
            index         <= '0;
            seen_zero     <= 1'b0;
            gap_error     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            active_lights <= '0;
            valid_code    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap      <= lights_state;
                        ones      <= '0;
                        index     <= '0;
                        seen_zero <= 1'b0;
                        gap_error <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    snap      <= {1'b0, snap[15:1]};
                    index     <= index + 4'd1;
                    ones      <= ones_next;
                    seen_zero <= seen_zero | ~lamp;
                    gap_error <= gap_next;
                    // Last lamp: publish results including this bit
                    if (index == 4'd15) begin
                        active_lights <= ones_next;
                        valid_code    <= ~gap_next;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lamp_state_decoder.md
# lamp_state_decoder

Sequential decoder for the 16-lamp bar. It samples a 16-bit lamp-state vector on request and serially scans it, one lamp per clock. It then reports how many lamps are lit and whether the pattern is a legal thermometer code (lamps 0..N-1 on, rest off). It sits on the read-back side of the lamp driver and recovers the active-light count from the lamp outputs for display and self-check.

## Interface
- No parameters: lamp count fixed at 16, count width fixed at 5.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-low.
- start  input  1  request pulse; accepted only in IDLE.
- lights_state  input  16  lamp vector; bit i = lamp i on; snapshotted when start is accepted.
- busy  output  1  high while scanning (SCAN state).
- done  output  1  one-cycle pulse, results updated.
- active_lights  output  5  number of lit lamps, 0..16; held until next done.
- valid_code  output  1  1 = snapshot was a legal thermometer code; held until next done.

## Operation
- States:
  - IDLE: wait for start. start=1 at an edge: copy lights_state to a 16-bit shift register, clear the ones counter (5 bit) and the seen_zero and gap_error flags, clear the index (4 bit), go to SCAN.
  - SCAN: each edge examines snapshot bit 0 (original lamp = index), then shifts right by one and increments the index.
    - bit=1: counter+1; if seen_zero=1, set gap_error.
    - bit=0: set seen_zero.
    - On index=15 (16th bit): write active_lights = final count (including this bit) and valid_code = ~final gap_error; set done; go to DONE.
  - DONE: one cycle; done=1; go to IDLE at next edge; start ignored.
- start in SCAN or DONE: ignored, no queueing.
- lights_state changes after acceptance: no effect (snapshot).
- Arithmetic:
  - Counter is 5 bits and cannot overflow; max value is 16 (16'hFFFF).
  - Index wraps 15 -> 0 only on leaving SCAN.
- Legal codes: 16'h0000 (0), 16'h0001..16'h7FFF contiguous-from-bit-0 (1..15), 16'hFFFF (16).
- Any 1 above a 0 makes the code illegal: valid_code=0, active_lights = popcount.
- Reset (rst_n=0 at an edge, in any state):
  - state goes to IDLE.
  - busy=0, done=0, active_lights=0, valid_code=0.
  - Internal counter, index and flags cleared.
  - A scan in progress is aborted with no done pulse.

## Timing
- Start accepted at edge E0: busy=1 after E0, through edge E0+16.
- Bits processed at edges E0+1..E0+16 (lamp 0 first).
- At edge E0+16: active_lights and valid_code update, done=1, busy=0.
- At edge E0+17: done=0, state IDLE.
- Earliest next acceptance: edge E0+18 (start sampled in IDLE).
- Throughput: one decode per 18 cycles with back-to-back start held high.
- Latency start-to-done: 16 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset and idle: hold rst_n=0 for 2 cycles, then release.
  - Required: busy=0, done=0, active_lights=0, valid_code=0.
  - No activity with start=0 for 40 cycles.
- Legal code, 16'h001F: start accepted at E0.
  - done only at E0+16 (one cycle wide); busy high E0..E0+16.
  - active_lights=5, valid_code=1.
- Extremes:
  - 16'h0000 -> active_lights=0, valid_code=1.
  - 16'hFFFF -> active_lights=16, valid_code=1.
  - 16'h7FFF -> 15, valid_code=1.
- Illegal codes:
  - 16'h00F5 -> active_lights=6, valid_code=0.
  - 16'h8000 -> 1, valid_code=0.
- Snapshot and start rules: start with 16'h0003.
  - Change lights_state to 16'hFFFF at E0+4.
  - Pulse start at E0+6 and during DONE.
  - Required: a single done with active_lights=2, valid_code=1; no second scan begins.
- Reset mid-scan: start with 16'h00FF, drive rst_n=0 at E0+8.
  - Required: busy=0 after that edge, no done pulse, outputs 0.
  - A following start with 16'h0007 yields 3, valid_code=1, after 16 cycles.
